string_sequencer: RTL and testbench
===================================

STRING_SEQUENCER -- requirements
Module: string_sequencer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 300, pixels per string per frame (1..65535).
REQ-002 SHALL have parameter FIFO_LATENCY, default 2, cycles from fifo_rd_en to valid fifo_data (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse starting a frame.
REQ-006 SHALL have port fifo_empty  input  1  pixel FIFO empty.
REQ-007 SHALL have port fifo_data  input  24  pixel FIFO read data, GRB.
REQ-008 SHALL have port fifo_rd_en  output  1  pixel FIFO pop, one-cycle pulse.
REQ-009 SHALL have port string_ready  input  1  string driver ready for a pixel or blank.
REQ-010 SHALL have port pixel_fifo_rd  output  1  to driver; pulses with fifo_rd_en.
REQ-011 SHALL have port pixel_data  output  24  to driver; registered pixel.
REQ-012 SHALL have port pixel_data_valid  output  1  to driver; one-cycle pixel strobe.
REQ-013 SHALL have port h_blank  output  1  to driver; one-cycle reset/latch request.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port underflow  output  1  sticky: FIFO empty when a pixel was due.

Function
REQ-017 SHALL implement states IDLE, REQ, FETCH, WAIT_READY, BLANK, BLANK_WAIT.
REQ-018 IDLE: frame_start -> REQ, pixel counter = 0, underflow cleared; frame_start in any other state ignored.
REQ-019 REQ: string_ready=1 and fifo_empty=0 -> assert fifo_rd_en and pixel_fifo_rd that cycle (t), -> FETCH.
REQ-020 REQ: string_ready=1 and fifo_empty=1 -> set underflow, stay in REQ (stall, no pop).
REQ-021 FETCH: latency counter; pixel_data loaded from fifo_data at edge ending cycle t+FIFO_LATENCY; pixel_data_valid high in cycle t+FIFO_LATENCY+1 only; -> WAIT_READY.
REQ-022 WAIT_READY: pixel counter increments once per pixel; wait for string_ready=1; then counter < NUM_PIXELS -> REQ, else -> BLANK.
REQ-023 string_ready SHALL NOT be sampled in FETCH (driver drops ready the cycle after pixel_fifo_rd).
REQ-024 BLANK: string_ready=1 -> h_blank high one cycle, -> BLANK_WAIT; no FIFO reads in BLANK or BLANK_WAIT.
REQ-025 BLANK_WAIT: ignore string_ready the first cycle, then wait for string_ready=1 -> frame_done one cycle, -> IDLE.
REQ-026 At most one of fifo_rd_en, pixel_data_valid, h_blank high in any cycle.
REQ-027 Pixel counter 16 bits, no wrap; exactly NUM_PIXELS pops per frame regardless of underflow stalls.
REQ-028 frame_start coincident with frame_done SHALL be ignored (state is not IDLE that cycle).

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counters 0, pixel_data 0, and all outputs 0, including mid-frame.
REQ-030 After rst_n deasserts, no output changes until a frame_start is seen in IDLE.

Verification
REQ-031 NUM_PIXELS=3, FIFO_LATENCY=2, FIFO holds A,B,C, string_ready model drops 1 cycle after pixel_fifo_rd for 20 cycles -> pops at t, valid at t+3 with A, then B, C, one h_blank, one frame_done, busy low after.
REQ-032 FIFO empty at frame_start, fills after 50 cycles -> no pop while empty, underflow=1 until next frame_start, frame still delivers 3 pixels.
REQ-033 string_ready held low 100 cycles in REQ -> no fifo_rd_en, no strobes until ready rises.
REQ-034 rst_n pulsed low during FETCH -> all outputs 0 same cycle, no pixel_data_valid afterwards, next frame_start runs full frame.
REQ-035 frame_start pulsed during WAIT_READY and coincident with frame_done -> ignored; exactly NUM_PIXELS pops counted.
REQ-036 FIFO_LATENCY=1 and 15 -> pixel_data_valid exactly FIFO_LATENCY+1 cycles after each pixel_fifo_rd, data matches FIFO order.

Source files
------------

// File: rtl/string_sequencer.sv
// Pixel sequencer: pops one frame of GRB pixels from a FIFO and hands them
// to a serial LED string driver, followed by a blank/latch request.
module string_sequencer #(
    parameter int NUM_PIXELS   = 300,
    parameter int FIFO_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_data,
    output logic        fifo_rd_en,
    input  logic        string_ready,
    output logic        pixel_fifo_rd,
    output logic [23:0] pixel_data,
    output logic        pixel_data_valid,
    output logic        h_blank,
    output logic        frame_done,
    output logic        busy,
    output logic        underflow
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FETCH,
        WAIT_READY,
        BLANK,
        BLANK_WAIT
    } state_t;

    localparam logic [15:0] NUM_PIX = 16'(NUM_PIXELS);
    localparam logic [3:0]  LAT     = 4'(FIFO_LATENCY);

    state_t      state_q;
    logic [15:0] pix_cnt_q;
    logic [3:0]  lat_q;
    logic [23:0] pix_q;
    logic        valid_q;
    logic        uflow_q;
    logic        bw_first_q;
    logic        pop;

    // Strobes decode from the state register so an async reset clears them at once.
    assign pop              = (state_q == REQ) && string_ready && !fifo_empty;
    assign fifo_rd_en       = pop;
    assign pixel_fifo_rd    = pop;
    assign h_blank          = (state_q == BLANK) && string_ready;
    assign frame_done       = (state_q == BLANK_WAIT) && !bw_first_q
                              && string_ready;
    assign busy             = (state_q != IDLE);
    assign pixel_data       = pix_q;
    assign pixel_data_valid = valid_q;
    assign underflow        = uflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pix_cnt_q  <= 16'd0;
            lat_q      <= 4'd0;
            pix_q      <= 24'd0;
            valid_q    <= 1'b0;
            uflow_q    <= 1'b0;
            bw_first_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q   <= REQ;
                        pix_cnt_q <= 16'd0;
                        uflow_q   <= 1'b0;
                    end
                end
                REQ: begin
                    if (string_ready) begin
                        if (fifo_empty) begin
                            uflow_q <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            lat_q   <= 4'd1;
                        end
                    end
                end
                FETCH: begin
                    if (lat_q == LAT) begin
                        pix_q     <= fifo_data;
                        valid_q   <= 1'b1;
                        pix_cnt_q <= pix_cnt_q + 16'd1;
                        state_q   <= WAIT_READY;
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end
                WAIT_READY: begin
                    if (string_ready) begin
                        state_q <= (pix_cnt_q < NUM_PIX) ? REQ : BLANK;
                    end
                end
                BLANK: begin
                    if (string_ready) begin
                        state_q    <= BLANK_WAIT;
                        bw_first_q <= 1'b1;
                    end
                end
                BLANK_WAIT: begin
                    bw_first_q <= 1'b0;
                    if (!bw_first_q && string_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_string_sequencer.sv
// Directed bench for string_sequencer: three instances at FIFO latency
// 2 (main), 1 and 15, each with its own FIFO and string-driver model.
module tb_string_sequencer;

    localparam int NP = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fs        [3] = '{default: 1'b0};
    logic        force_low [3] = '{default: 1'b0};
    logic        empty     [3];
    logic        rdy       [3];
    logic [23:0] fdata     [3];
    logic        rd        [3];
    logic        prd       [3];
    logic [23:0] pdata     [3];
    logic        vld       [3];
    logic        hb        [3];
    logic        fd        [3];
    logic        bsy       [3];
    logic        uf        [3];

    int          fill   [3] = '{default: 0};
    int          popped [3] = '{default: 0};
    int          drop   [3] = '{default: 0};
    logic [23:0] pipe   [3][16] = '{default: '{default: 24'h0}};
    int          cyc = 0;

    int          pop_t [3][$];
    int          vld_t [3][$];
    logic [23:0] vld_d [3][$];
    int          hb_n  [3] = '{default: 0};
    int          fd_n  [3] = '{default: 0};
    int          bad_n [3] = '{default: 0};

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(int k);
        return (k == 1) ? 1 : ((k == 2) ? 15 : 2);
    endfunction

    function automatic logic [23:0] word(int k, int n);
        return 24'hA00000 | (24'(k) << 16) | 24'(n + 1);
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int L = (k == 1) ? 1 : ((k == 2) ? 15 : 2);
        string_sequencer #(
            .NUM_PIXELS  (NP),
            .FIFO_LATENCY(L)
        ) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .frame_start     (fs[k]),
            .fifo_empty      (empty[k]),
            .fifo_data       (fdata[k]),
            .fifo_rd_en      (rd[k]),
            .string_ready    (rdy[k]),
            .pixel_fifo_rd   (prd[k]),
            .pixel_data      (pdata[k]),
            .pixel_data_valid(vld[k]),
            .h_blank         (hb[k]),
            .frame_done      (fd[k]),
            .busy            (bsy[k]),
            .underflow       (uf[k])
        );
    end

    // FIFO read pipeline and string-driver ready model
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            empty[k] = (popped[k] >= fill[k]);
            fdata[k] = pipe[k][lat_of(k) - 1];
            rdy[k]   = !force_low[k] && (drop[k] == 0);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            for (int s = 15; s > 0; s--) pipe[k][s] <= pipe[k][s - 1];
            pipe[k][0] <= rd[k] ? word(k, popped[k]) : 24'h0;
            if (rd[k]) begin
                popped[k] <= popped[k] + 1;
                drop[k]   <= 20;
            end else if (drop[k] > 0) begin
                drop[k] <= drop[k] - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd[k] === 1'b1) pop_t[k].push_back(cyc);
            if (vld[k] === 1'b1) begin
                vld_t[k].push_back(cyc);
                vld_d[k].push_back(pdata[k]);
            end
            if (hb[k] === 1'b1) hb_n[k]++;
            if (fd[k] === 1'b1) fd_n[k]++;
            if ((int'(rd[k]) + int'(vld[k]) + int'(hb[k])) > 1
                || prd[k] !== rd[k]) bad_n[k]++;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(int k);
        fs[k] = 1'b1;
        step(1);
        fs[k] = 1'b0;
    endtask

    task automatic wait_idle(int k, int budget, output bit to);
        int n;
        n = 0;
        while (bsy[k] && n < budget) begin
            step(1);
            n++;
        end
        to = bsy[k];
    endtask

    task automatic test_reset();
        logic [6:0] got;
        rst_n = 1'b0;
        step(3);
        for (int k = 0; k < 3; k++) begin
            got = {rd[k], prd[k], vld[k], hb[k], fd[k], bsy[k], uf[k]};
            vectors++;
            if (got !== 7'b0) begin
                miscompares++;
                $display("FAIL reset_ctl[%0d] got %b want 0000000", k, got);
            end
            vectors++;
            if (pdata[k] !== 24'h0) begin
                miscompares++;
                $display("FAIL reset_data[%0d] got %h want 000000", k, pdata[k]);
            end
        end
        rst_n = 1'b1;
        step(10);
        for (int k = 0; k < 3; k++) begin
            got = {rd[k], prd[k], vld[k], hb[k], fd[k], bsy[k], uf[k]};
            vectors++;
            if (got !== 7'b0) begin
                miscompares++;
                $display("FAIL post_reset_ctl[%0d] got %b want 0000000", k, got);
            end
        end
    endtask

    task automatic test_basic();
        int bp, bv, h0, f0, base, n;
        bit to;
        bp = pop_t[0].size(); bv = vld_t[0].size();
        h0 = hb_n[0]; f0 = fd_n[0]; base = popped[0];
        fill[0] += 3;
        pulse(0);
        wait_idle(0, 400, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL basic_done busy=%b want 0", bsy[0]);
        end
        vectors++;
        if (pop_t[0].size() - bp != 3) begin
            miscompares++;
            $display("FAIL basic_pops got %0d want 3", pop_t[0].size() - bp);
        end
        vectors++;
        if (vld_t[0].size() - bv != 3) begin
            miscompares++;
            $display("FAIL basic_valids got %0d want 3", vld_t[0].size() - bv);
        end
        n = vld_t[0].size() - bv;
        if (pop_t[0].size() - bp < n) n = pop_t[0].size() - bp;
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (vld_t[0][bv + i] - pop_t[0][bp + i] != 3) begin
                miscompares++;
                $display("FAIL basic_lat[%0d] got %0d want 3", i,
                         vld_t[0][bv + i] - pop_t[0][bp + i]);
            end
            vectors++;
            if (vld_d[0][bv + i] !== word(0, base + i)) begin
                miscompares++;
                $display("FAIL basic_data[%0d] got %h want %h", i,
                         vld_d[0][bv + i], word(0, base + i));
            end
        end
        vectors++;
        if (hb_n[0] - h0 != 1 || fd_n[0] - f0 != 1) begin
            miscompares++;
            $display("FAIL basic_blank hb=%0d fd=%0d want 1 1",
                     hb_n[0] - h0, fd_n[0] - f0);
        end
        vectors++;
        if (uf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_uflow got %b want 0", uf[0]);
        end
    endtask

    task automatic test_underflow();
        int bp, bv, base, n;
        bit to;
        bp = pop_t[0].size(); bv = vld_t[0].size(); base = popped[0];
        pulse(0);
        step(50);
        vectors++;
        if (pop_t[0].size() != bp || uf[0] !== 1'b1 || bsy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL uflow_stall pops=%0d uf=%b busy=%b want 0 1 1",
                     pop_t[0].size() - bp, uf[0], bsy[0]);
        end
        fill[0] += 3;
        wait_idle(0, 400, to);
        vectors++;
        if (to || pop_t[0].size() - bp != 3) begin
            miscompares++;
            $display("FAIL uflow_frame busy=%b pops=%0d want 0 3",
                     bsy[0], pop_t[0].size() - bp);
        end
        n = vld_t[0].size() - bv;
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL uflow_valids got %0d want 3", n);
        end
        for (int i = 0; i < n && i < 3; i++) begin
            vectors++;
            if (vld_d[0][bv + i] !== word(0, base + i)) begin
                miscompares++;
                $display("FAIL uflow_data[%0d] got %h want %h", i,
                         vld_d[0][bv + i], word(0, base + i));
            end
        end
        vectors++;
        if (uf[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL uflow_sticky got %b want 1", uf[0]);
        end
        fill[0] += 3;
        pulse(0);
        vectors++;
        if (uf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL uflow_clear got %b want 0", uf[0]);
        end
        wait_idle(0, 400, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL uflow_rerun busy=%b want 0", bsy[0]);
        end
    endtask

    task automatic test_ready_low();
        int bp, bv;
        bit to;
        bp = pop_t[0].size(); bv = vld_t[0].size();
        force_low[0] = 1'b1;
        fill[0] += 3;
        pulse(0);
        step(100);
        vectors++;
        if (pop_t[0].size() != bp || vld_t[0].size() != bv
            || bsy[0] !== 1'b1 || uf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rdylow_hold pops=%0d vld=%0d busy=%b uf=%b want 0 0 1 0",
                     pop_t[0].size() - bp, vld_t[0].size() - bv, bsy[0], uf[0]);
        end
        force_low[0] = 1'b0;
        wait_idle(0, 400, to);
        vectors++;
        if (to || pop_t[0].size() - bp != 3) begin
            miscompares++;
            $display("FAIL rdylow_frame busy=%b pops=%0d want 0 3",
                     bsy[0], pop_t[0].size() - bp);
        end
    endtask

    task automatic test_reset_fetch();
        int bp, bv, base, n;
        logic [6:0] got;
        bit to;
        fill[0] += 3;
        pulse(0);
        n = 0;
        while (!rd[0] && n < 20) begin
            step(1);
            n++;
        end
        vectors++;
        if (rd[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rstf_pop rd=%b want 1", rd[0]);
        end
        step(1);
        rst_n = 1'b0;
        #1;
        got = {rd[0], prd[0], vld[0], hb[0], fd[0], bsy[0], uf[0]};
        vectors++;
        if (got !== 7'b0 || pdata[0] !== 24'h0) begin
            miscompares++;
            $display("FAIL rstf_clear ctl=%b data=%h want 0000000 000000",
                     got, pdata[0]);
        end
        bv = vld_t[0].size();
        step(3);
        rst_n = 1'b1;
        step(10);
        vectors++;
        if (vld_t[0].size() != bv || bsy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rstf_quiet vld=%0d busy=%b want 0 0",
                     vld_t[0].size() - bv, bsy[0]);
        end
        fill[0] += 1;
        bp = pop_t[0].size(); base = popped[0];
        pulse(0);
        wait_idle(0, 400, to);
        n = vld_t[0].size() - bv;
        vectors++;
        if (to || pop_t[0].size() - bp != 3 || n != 3) begin
            miscompares++;
            $display("FAIL rstf_rerun busy=%b pops=%0d vld=%0d want 0 3 3",
                     bsy[0], pop_t[0].size() - bp, n);
        end
        for (int i = 0; i < n && i < 3; i++) begin
            vectors++;
            if (vld_d[0][bv + i] !== word(0, base + i)) begin
                miscompares++;
                $display("FAIL rstf_data[%0d] got %h want %h", i,
                         vld_d[0][bv + i], word(0, base + i));
            end
        end
    endtask

    task automatic test_ignore_fs();
        int bp, h0, f0, n;
        fill[0] += 3;
        bp = pop_t[0].size(); h0 = hb_n[0]; f0 = fd_n[0];
        pulse(0);
        n = 0;
        while (!vld[0] && n < 100) begin
            step(1);
            n++;
        end
        pulse(0);
        n = 0;
        while (!hb[0] && n < 300) begin
            step(1);
            n++;
        end
        vectors++;
        if (hb[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ignfs_blank hb=%b want 1", hb[0]);
        end
        step(2);
        fs[0] = 1'b1;
        #1;
        vectors++;
        if (fd[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ignfs_done_cycle fd=%b want 1", fd[0]);
        end
        step(1);
        fs[0] = 1'b0;
        step(10);
        vectors++;
        if (bsy[0] !== 1'b0 || pop_t[0].size() - bp != 3) begin
            miscompares++;
            $display("FAIL ignfs_result busy=%b pops=%0d want 0 3",
                     bsy[0], pop_t[0].size() - bp);
        end
        vectors++;
        if (hb_n[0] - h0 != 1 || fd_n[0] - f0 != 1) begin
            miscompares++;
            $display("FAIL ignfs_strobes hb=%0d fd=%0d want 1 1",
                     hb_n[0] - h0, fd_n[0] - f0);
        end
    endtask

    task automatic test_latency();
        int bp[3], bv[3], base[3];
        int n;
        bit to;
        for (int k = 1; k < 3; k++) begin
            bp[k] = pop_t[k].size(); bv[k] = vld_t[k].size();
            base[k] = popped[k];
            fill[k] += 3;
            fs[k] = 1'b1;
        end
        step(1);
        fs[1] = 1'b0;
        fs[2] = 1'b0;
        for (int k = 1; k < 3; k++) begin
            wait_idle(k, 600, to);
            n = vld_t[k].size() - bv[k];
            vectors++;
            if (to || pop_t[k].size() - bp[k] != 3 || n != 3) begin
                miscompares++;
                $display("FAIL lat%0d_frame busy=%b pops=%0d vld=%0d want 0 3 3",
                         lat_of(k), bsy[k], pop_t[k].size() - bp[k], n);
            end
            if (pop_t[k].size() - bp[k] < n) n = pop_t[k].size() - bp[k];
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (vld_t[k][bv[k] + i] - pop_t[k][bp[k] + i] != lat_of(k) + 1) begin
                    miscompares++;
                    $display("FAIL lat%0d_delay[%0d] got %0d want %0d", lat_of(k), i,
                             vld_t[k][bv[k] + i] - pop_t[k][bp[k] + i], lat_of(k) + 1);
                end
                vectors++;
                if (vld_d[k][bv[k] + i] !== word(k, base[k] + i)) begin
                    miscompares++;
                    $display("FAIL lat%0d_data[%0d] got %h want %h", lat_of(k), i,
                             vld_d[k][bv[k] + i], word(k, base[k] + i));
                end
            end
        end
    endtask

    task automatic test_exclusive();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (bad_n[k] != 0) begin
                miscompares++;
                $display("FAIL exclusive[%0d] overlap_cycles=%0d want 0", k, bad_n[k]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_underflow();
        test_ready_low();
        test_reset_fetch();
        test_ignore_fs();
        test_latency();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
